// File: rtl/ddr_pkg.sv
// Shared DDR1 command codes, bank states and default timing constants.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package ddr_pkg;

  // Function codes shared with address_decoder.
  typedef enum logic [3:0] {
    CMD_DESELECT  = 4'd0,
    CMD_NOP       = 4'd1,
    CMD_ACTIVE    = 4'd2,
    CMD_READ      = 4'd3,
    CMD_WRITE     = 4'd4,
    CMD_BST       = 4'd5,
    CMD_PRECHARGE = 4'd6,
    CMD_REFRESH   = 4'd7,
    CMD_MRS       = 4'd8
  } cmd_t;

  typedef enum logic [1:0] {
    BANK_IDLE,
    BANK_ACTIVATING,
    BANK_ACTIVE,
    BANK_PRECHARGING
  } bank_state_t;

  localparam int DEF_T_RCD = 3;
  localparam int DEF_T_RP  = 3;
  localparam int DEF_T_AP  = 2;
  localparam int DEF_T_MRD = 2;
  localparam int DEF_T_RFC = 10;

  function automatic int max_of4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

  // Pins are active low; with CSn low the RAS/CAS/WE triple covers all 8 codes.
  function automatic cmd_t decode_pins(input logic cs_n, input logic ras_n,
                                       input logic cas_n, input logic we_n);
    cmd_t c;
    if (cs_n) begin
      c = CMD_DESELECT;
    end else begin
      case ({ras_n, cas_n, we_n})
        3'b111:  c = CMD_NOP;
        3'b011:  c = CMD_ACTIVE;
        3'b101:  c = CMD_READ;
        3'b100:  c = CMD_WRITE;
        3'b110:  c = CMD_BST;
        3'b010:  c = CMD_PRECHARGE;
        3'b001:  c = CMD_REFRESH;
        default: c = CMD_MRS;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/ddr_bank_fsm.sv
// One SDRAM bank: IDLE/ACTIVATING/ACTIVE/PRECHARGING state with a timing counter.
// Latency: requests take effect on the next rising edge; state is a register.
// Backpressure: none; the parent only raises a request when it is legal for this bank.
module ddr_bank_fsm
  import ddr_pkg::*;
#(
  parameter int CNT_W = 4,
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP,
  parameter int T_AP  = DEF_T_AP
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        activate,
  input  logic        precharge,
  input  logic        auto_pre,
  output bank_state_t state
);

  logic [CNT_W-1:0] cnt;

  // A timed state leaves on the edge where its counter would reach zero, so a
  // parameter of 1 (counter loaded with 0) completes on the very next clock.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= BANK_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        BANK_IDLE: begin
          if (activate) begin
            state <= BANK_ACTIVATING;
            cnt   <= CNT_W'(T_RCD - 1);
          end
        end
        BANK_ACTIVATING: begin
          if (precharge) begin
            state <= BANK_PRECHARGING;
            cnt   <= CNT_W'(T_RP - 1);
          end else if (cnt <= CNT_W'(1)) begin
            state <= BANK_ACTIVE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        BANK_ACTIVE: begin
          if (precharge) begin
            state <= BANK_PRECHARGING;
            cnt   <= CNT_W'(T_RP - 1);
          end else if (auto_pre) begin
            state <= BANK_PRECHARGING;
            cnt   <= CNT_W'(T_RP + T_AP - 1);
          end
        end
        BANK_PRECHARGING: begin
          if (cnt <= CNT_W'(1)) begin
            state <= BANK_IDLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: begin
          state <= BANK_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/ddr_cmd_decoder.sv
// DDR1 command front end: pin decode, per-bank timing, legality check, lockout.
// Latency: adf/address/cmd_illegal registered, valid 1 clock after the pins are sampled.
// Backpressure: none; illegal commands are dropped, flagged and replaced by NOP.
module ddr_cmd_decoder
  import ddr_pkg::*;
#(
  parameter int T_RCD = DEF_T_RCD,
  parameter int T_RP  = DEF_T_RP,
  parameter int T_AP  = DEF_T_AP,
  parameter int T_MRD = DEF_T_MRD,
  parameter int T_RFC = DEF_T_RFC
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        CSn,
  input  logic        RASn,
  input  logic        CASn,
  input  logic        WEn,
  input  logic [15:0] address_in,
  output logic [3:0]  adf,
  output logic [15:0] address,
  output logic [3:0]  bank_open,
  output logic        busy,
  output logic        cmd_illegal
);

  localparam int CNT_W = $clog2(max_of4(T_RCD, T_RP + T_AP, T_MRD, T_RFC) + 1);

  cmd_t             cmd;
  logic [1:0]       tgt;
  logic             a10;
  bank_state_t      bank_state [4];
  logic [CNT_W-1:0] lock_cnt;
  logic             all_idle;
  logic             legal;
  logic [3:0]       act_req;
  logic [3:0]       pre_req;
  logic [3:0]       apre_req;

  assign cmd  = decode_pins(CSn, RASn, CASn, WEn);
  assign tgt  = address_in[15:14];
  assign a10  = address_in[10];
  assign busy = (lock_cnt != '0);

  // Legality uses the current (pre-transition) bank states and lockout.
  always_comb begin
    all_idle = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (bank_state[b] != BANK_IDLE) all_idle = 1'b0;
    end
    legal = 1'b1;
    if (cmd != CMD_DESELECT && cmd != CMD_NOP && busy) begin
      legal = 1'b0;
    end else begin
      case (cmd)
        CMD_ACTIVE:             legal = (bank_state[tgt] == BANK_IDLE);
        CMD_READ, CMD_WRITE:    legal = (bank_state[tgt] == BANK_ACTIVE);
        CMD_REFRESH, CMD_MRS:   legal = all_idle;
        default:                legal = 1'b1;
      endcase
    end
  end

  // Per-bank requests; precharge of an idle/precharging bank is ignored by the bank itself.
  always_comb begin
    act_req  = '0;
    pre_req  = '0;
    apre_req = '0;
    for (int b = 0; b < 4; b++) begin
      act_req[b]  = legal && (cmd == CMD_ACTIVE) && (tgt == 2'(b));
      pre_req[b]  = legal && (cmd == CMD_PRECHARGE) && (a10 || tgt == 2'(b));
      apre_req[b] = legal && (cmd == CMD_READ || cmd == CMD_WRITE) && a10 && (tgt == 2'(b));
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_bank
    ddr_bank_fsm #(
      .CNT_W (CNT_W),
      .T_RCD (T_RCD),
      .T_RP  (T_RP),
      .T_AP  (T_AP)
    ) u_bank (
      .clk       (clk),
      .rstn      (rstn),
      .activate  (act_req[b]),
      .precharge (pre_req[b]),
      .auto_pre  (apre_req[b]),
      .state     (bank_state[b])
    );
    assign bank_open[b] = (bank_state[b] == BANK_ACTIVE);
  end

  // Global MRS/REFRESH lockout counter, saturating at zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      lock_cnt <= '0;
    end else if (legal && cmd == CMD_MRS) begin
      lock_cnt <= CNT_W'(T_MRD - 1);
    end else if (legal && cmd == CMD_REFRESH) begin
      lock_cnt <= CNT_W'(T_RFC - 1);
    end else if (lock_cnt != '0) begin
      lock_cnt <= lock_cnt - CNT_W'(1);
    end
  end

  // Output registers toward address_decoder; rejected commands become NOP.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      adf         <= 4'd0;
      address     <= 16'd0;
      cmd_illegal <= 1'b0;
    end else begin
      adf         <= legal ? cmd : CMD_NOP;
      address     <= address_in;
      cmd_illegal <= !legal;
    end
  end

endmodule

// File: tb/tb_ddr_cmd_decoder.sv
// Testbench for ddr_cmd_decoder: directed scenarios plus randomized commands.
// Reference model tracks per-bank ready/idle times and a lockout end time.
// Inputs driven on the falling edge, outputs sampled 1ns after the rising edge.
module tb_ddr_cmd_decoder;

  localparam int T_RCD = 3;
  localparam int T_RP  = 3;
  localparam int T_AP  = 2;
  localparam int T_MRD = 2;
  localparam int T_RFC = 10;

  logic        clk = 1'b0;
  logic        rstn = 1'b1;
  logic        CSn = 1'b1, RASn = 1'b1, CASn = 1'b1, WEn = 1'b1;
  logic [15:0] address_in = 16'd0;
  logic [3:0]  adf;
  logic [15:0] address;
  logic [3:0]  bank_open;
  logic        busy;
  logic        cmd_illegal;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Model: a bank is "opened" from ACTIVE until a precharge; t_b is the cycle from
  // which it is usable (opened) or idle again (not opened).
  bit   opened [4];
  int   t_b [4];
  int   lock_until;
  logic [3:0] exp_adf;
  logic       exp_ill;
  logic [3:0] exp_open;
  logic       exp_busy;

  always #5 clk = ~clk;

  ddr_cmd_decoder dut (
    .clk         (clk),
    .rstn        (rstn),
    .CSn         (CSn),
    .RASn        (RASn),
    .CASn        (CASn),
    .WEn         (WEn),
    .address_in  (address_in),
    .adf         (adf),
    .address     (address),
    .bank_open   (bank_open),
    .busy        (busy),
    .cmd_illegal (cmd_illegal)
  );

  // {CSn,RASn,CASn,WEn} for each function code.
  function automatic logic [3:0] pins_for(input int code);
    case (code)
      0: return 4'b1111;
      1: return 4'b0111;
      2: return 4'b0011;
      3: return 4'b0101;
      4: return 4'b0100;
      5: return 4'b0110;
      6: return 4'b0010;
      7: return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic model_reset();
    for (int b = 0; b < 4; b++) begin
      opened[b] = 1'b0;
      t_b[b]    = cyc;
    end
    lock_until = cyc;
  endtask

  // Apply one command for one clock, advance the model and compute expectations.
  task automatic drive(input int code, input logic [15:0] addr);
    int bk;
    bit a10, legal, all_idle, busy_now;
    @(negedge clk);
    {CSn, RASn, CASn, WEn} = pins_for(code);
    address_in = addr;
    @(posedge clk);
    cyc++;
    bk = int'(addr[15:14]);
    a10 = addr[10];
    busy_now = cyc < lock_until;
    all_idle = 1'b1;
    for (int b = 0; b < 4; b++) if (opened[b] || cyc < t_b[b]) all_idle = 1'b0;
    if (code <= 1)      legal = 1'b1;
    else if (busy_now)  legal = 1'b0;
    else if (code == 2) legal = !opened[bk] && cyc >= t_b[bk];
    else if (code == 3 || code == 4) legal = opened[bk] && cyc >= t_b[bk];
    else if (code == 7 || code == 8) legal = all_idle;
    else legal = 1'b1;
    if (legal) begin
      if (code == 2) begin
        opened[bk] = 1'b1; t_b[bk] = cyc + T_RCD;
      end else if ((code == 3 || code == 4) && a10) begin
        opened[bk] = 1'b0; t_b[bk] = cyc + T_RP + T_AP;
      end else if (code == 6) begin
        for (int b = 0; b < 4; b++)
          if ((a10 || b == bk) && opened[b]) begin
            opened[b] = 1'b0; t_b[b] = cyc + T_RP;
          end
      end else if (code == 7) lock_until = cyc + T_RFC;
      else if (code == 8) lock_until = cyc + T_MRD;
    end
    exp_adf = legal ? 4'(code) : 4'd1;
    exp_ill = !legal;
    for (int b = 0; b < 4; b++) exp_open[b] = opened[b] && (cyc + 1) >= t_b[b];
    exp_busy = (cyc + 1) < lock_until;
    #1;
  endtask

  task automatic test_reset();
    #2 rstn = 1'b0;
    #1;
    checks++; if (adf !== 4'd0) begin errors++; $display("FAIL rst_adf: got %0d want 0", adf); end
    checks++; if (address !== 16'd0) begin errors++; $display("FAIL rst_addr: got %h want 0000", address); end
    checks++; if (bank_open !== 4'd0) begin errors++; $display("FAIL rst_open: got %b want 0000", bank_open); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++; if (cmd_illegal !== 1'b0) begin errors++; $display("FAIL rst_ill: got %b want 0", cmd_illegal); end
    repeat (2) @(posedge clk);
    {CSn, RASn, CASn, WEn} = 4'b0111;
    @(negedge clk) rstn = 1'b1;
    model_reset();
    drive(0, 16'h1234);
    checks++; if (adf !== 4'd0) begin errors++; $display("FAIL desel_adf: got %0d want 0", adf); end
    checks++; if (address !== 16'h1234) begin errors++; $display("FAIL desel_addr: got %h want 1234", address); end
    for (int i = 0; i < 4; i++) begin
      drive(1, 16'($urandom));
      checks++; if (adf !== 4'd1) begin errors++; $display("FAIL nop_adf: got %0d want 1", adf); end
      checks++; if (bank_open !== 4'd0 || cmd_illegal !== 1'b0)
        begin errors++; $display("FAIL nop_state: got open=%b ill=%b want 0000/0", bank_open, cmd_illegal); end
    end
  endtask

  task automatic test_activate_read();
    drive(2, {2'b10, 14'h01A5});
    checks++; if (adf !== 4'd2 || cmd_illegal !== 1'b0)
      begin errors++; $display("FAIL act_b2: got adf=%0d ill=%b want 2/0", adf, cmd_illegal); end
    checks++; if (address !== 16'h81A5) begin errors++; $display("FAIL act_addr: got %h want 81a5", address); end
    drive(1, 16'h0); drive(1, 16'h0);
    drive(3, {2'b10, 14'h0010});
    checks++; if (adf !== 4'd3 || cmd_illegal !== 1'b0)
      begin errors++; $display("FAIL read_b2: got adf=%0d ill=%b want 3/0", adf, cmd_illegal); end
    checks++; if (bank_open !== 4'b0100) begin errors++; $display("FAIL open_b2: got %b want 0100", bank_open); end
  endtask

  task automatic test_early_read();
    drive(2, {2'b01, 14'h0033});
    drive(1, 16'h0);
    drive(3, {2'b01, 14'h0008});
    checks++; if (adf !== 4'd1 || cmd_illegal !== 1'b1)
      begin errors++; $display("FAIL early_read: got adf=%0d ill=%b want 1/1", adf, cmd_illegal); end
    drive(3, {2'b01, 14'h0008});
    checks++; if (adf !== 4'd3 || cmd_illegal !== 1'b0)
      begin errors++; $display("FAIL ready_read: got adf=%0d ill=%b want 3/0", adf, cmd_illegal); end
  endtask

  task automatic test_precharge_all();
    drive(2, 16'h0010);
    drive(2, 16'hC020);
    drive(1, 16'h0); drive(1, 16'h0); drive(1, 16'h0);
    checks++; if (bank_open !== 4'b1111) begin errors++; $display("FAIL all_open: got %b want 1111", bank_open); end
    drive(6, 16'h0400);
    checks++; if (bank_open !== 4'b0000 || adf !== 4'd6)
      begin errors++; $display("FAIL pre_all: got open=%b adf=%0d want 0000/6", bank_open, adf); end
    drive(2, 16'h0000);
    checks++; if (cmd_illegal !== 1'b1 || adf !== 4'd1)
      begin errors++; $display("FAIL act_during_rp: got ill=%b adf=%0d want 1/1", cmd_illegal, adf); end
    drive(1, 16'h0);
    drive(2, 16'h0000);
    checks++; if (cmd_illegal !== 1'b0 || adf !== 4'd2)
      begin errors++; $display("FAIL act_after_rp: got ill=%b adf=%0d want 0/2", cmd_illegal, adf); end
  endtask

  task automatic test_mrs();
    drive(6, 16'h0400);
    drive(1, 16'h0); drive(1, 16'h0);
    drive(8, 16'h0032);
    checks++; if (adf !== 4'd8 || busy !== 1'b1 || cmd_illegal !== 1'b0)
      begin errors++; $display("FAIL mrs: got adf=%0d busy=%b ill=%b want 8/1/0", adf, busy, cmd_illegal); end
    drive(2, 16'h0000);
    checks++; if (cmd_illegal !== 1'b1 || busy !== 1'b0)
      begin errors++; $display("FAIL act_busy: got ill=%b busy=%b want 1/0", cmd_illegal, busy); end
    drive(2, 16'h0000);
    checks++; if (cmd_illegal !== 1'b0 || adf !== 4'd2)
      begin errors++; $display("FAIL act_after_mrs: got ill=%b adf=%0d want 0/2", cmd_illegal, adf); end
  endtask

  task automatic test_autopre_and_reset();
    drive(1, 16'h0); drive(1, 16'h0); drive(1, 16'h0);
    drive(4, 16'h0400);
    checks++; if (adf !== 4'd4 || bank_open[0] !== 1'b0)
      begin errors++; $display("FAIL wr_ap: got adf=%0d open0=%b want 4/0", adf, bank_open[0]); end
    drive(1, 16'h0); drive(1, 16'h0); drive(1, 16'h0);
    drive(2, 16'h0000);
    checks++; if (cmd_illegal !== 1'b1) begin errors++; $display("FAIL act_during_ap: got ill=%b want 1", cmd_illegal); end
    drive(2, 16'h0000);
    checks++; if (cmd_illegal !== 1'b0 || adf !== 4'd2)
      begin errors++; $display("FAIL act_after_ap: got ill=%b adf=%0d want 0/2", cmd_illegal, adf); end
    drive(2, 16'hC000);
    drive(1, 16'h0); drive(1, 16'h0);
    drive(2, 16'h4123);
    #3 rstn = 1'b0;
    #1;
    checks++; if (adf !== 4'd0 || address !== 16'd0 || bank_open !== 4'd0 || busy !== 1'b0 || cmd_illegal !== 1'b0)
      begin errors++; $display("FAIL midop_rst: got adf=%0d addr=%h open=%b busy=%b ill=%b want all 0",
                               adf, address, bank_open, busy, cmd_illegal); end
    {CSn, RASn, CASn, WEn} = 4'b0111;
    @(negedge clk) rstn = 1'b1;
    model_reset();
    drive(3, 16'hC000);
    checks++; if (cmd_illegal !== 1'b1 || bank_open !== 4'd0)
      begin errors++; $display("FAIL read_after_rst: got ill=%b open=%b want 1/0000", cmd_illegal, bank_open); end
  endtask

  task automatic test_random();
    int code;
    logic [15:0] addr;
    for (int i = 0; i < 400; i++) begin
      code = $urandom_range(0, 8);
      addr = 16'($urandom);
      addr[10] = ($urandom_range(0, 3) == 0);
      drive(code, addr);
      checks++; if (adf !== exp_adf) begin errors++; $display("FAIL rnd_adf[%0d]: got %0d want %0d", i, adf, exp_adf); end
      checks++; if (address !== addr) begin errors++; $display("FAIL rnd_addr[%0d]: got %h want %h", i, address, addr); end
      checks++; if (cmd_illegal !== exp_ill) begin errors++; $display("FAIL rnd_ill[%0d]: got %b want %b", i, cmd_illegal, exp_ill); end
      checks++; if (bank_open !== exp_open) begin errors++; $display("FAIL rnd_open[%0d]: got %b want %b", i, bank_open, exp_open); end
      checks++; if (busy !== exp_busy) begin errors++; $display("FAIL rnd_busy[%0d]: got %b want %b", i, busy, exp_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_activate_read();
    test_early_read();
    test_precharge_all();
    test_mrs();
    test_autopre_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
